// File: rtl/sar_logic.sv
// sar_logic: successive-approximation controller that binary-searches the comparator MSB first and latches the result with a ready pulse
module sar_logic #(
  parameter int NBITS         = 8,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic             clk_sar,
  input  logic             reset,
  input  logic             sample,
  input  logic             comp_in,
  output logic [NBITS-1:0] dac_code,
  output logic [NBITS-1:0] data_out,
  output logic             ready,
  output logic             busy
);
  localparam int KW = $clog2(NBITS);
  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} state_t;
  localparam state_t START = (SETTLE_CYCLES > 0) ? SETTLE : DECIDE;
  localparam logic [3:0] SC = 4'(SETTLE_CYCLES);
  localparam logic [KW-1:0] KMAX = KW'(NBITS - 1);
  localparam logic [NBITS-1:0] MSB = {1'b1, {(NBITS-1){1'b0}}};
  state_t state_q, state_d;
  logic [NBITS-1:0] dac_q, dac_d, data_q, data_d;
  logic ready_q, ready_d, busy_q, busy_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0] cnt_q, cnt_d;
  // state and datapath registers; reset aborts any conversion without a ready pulse
  always_ff @(posedge clk_sar) begin
    if (reset) begin
      state_q <= IDLE;
      dac_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      k_q     <= KMAX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: settle phase (if any) precedes every decision, last decision returns to idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = sample ? START : IDLE;
      SETTLE:  state_d = (cnt_q == 4'd1) ? DECIDE : SETTLE;
      DECIDE:  state_d = (k_q == '0) ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end
  // next register values: bit k resolved and bit k-1 trialled in one write
  always_comb begin
    dac_d   = dac_q;
    data_d  = data_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (sample) begin
        dac_d  = MSB;
        k_d    = KMAX;
        busy_d = 1'b1;
        cnt_d  = SC;
      end
      SETTLE: cnt_d = cnt_q - 4'd1;
      DECIDE: begin
        dac_d[k_q] = comp_in;
        if (k_q != '0) begin
          dac_d[k_q - 1'b1] = 1'b1;
          k_d   = k_q - 1'b1;
          cnt_d = SC;
        end else begin
          data_d  = dac_d;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end
  assign dac_code = dac_q;
  assign data_out = data_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_sar_logic.sv
// tb_sar_logic: scoreboard bench for sar_logic with settle 0 and settle 2 instances sharing stimulus
module tb_sar_logic;
  typedef struct {
    logic [7:0] vin;
    int         acc;
    int         done;
  } exp_t;
  localparam int S0 = 0;
  localparam int S2 = 2;
  localparam int L0 = 8 * (S0 + 1);
  localparam int L2 = 8 * (S2 + 1);
  logic clk = 0;
  logic reset = 1;
  logic sample = 0;
  logic [7:0] vin0 = 0, vin2 = 0;
  logic [7:0] dac0, dac2, data0, data2;
  logic rdy0, rdy2, busy0, busy2;
  logic comp0, comp2;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  bit held = 0;
  int prev_r0 = -1;
  logic [7:0] last0 = 0, last2 = 0;
  exp_t q0[$], q2[$];
  exp_t e0, e2;
  assign comp0 = (vin0 >= dac0);
  assign comp2 = (vin2 >= dac2);
  sar_logic #(.NBITS(8), .SETTLE_CYCLES(S0)) u0 (
    .clk_sar(clk), .reset(reset), .sample(sample), .comp_in(comp0),
    .dac_code(dac0), .data_out(data0), .ready(rdy0), .busy(busy0)
  );
  sar_logic #(.NBITS(8), .SETTLE_CYCLES(S2)) u2 (
    .clk_sar(clk), .reset(reset), .sample(sample), .comp_in(comp2),
    .dac_code(dac2), .data_out(data2), .ready(rdy2), .busy(busy2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask
  // after j decisions the trial code is the top j bits of vin followed by a single 1
  function automatic int trial(input logic [7:0] vin, input int j);
    int m;
    m = (1 << (8 - j)) - 1;
    return (int'(vin) & ~m & 'hFF) | (1 << (7 - j));
  endfunction
  task automatic mon(input string nm, input int s, input bit have, input exp_t e,
                     input logic [7:0] dac, input logic [7:0] data, input logic rdy,
                     input logic bsy, input logic [7:0] last);
    if (have && cyc < e.done) begin
      chk({nm, "_busy"}, int'(bsy), 1);
      chk({nm, "_ready_early"}, int'(rdy), 0);
      chk({nm, "_dac_trial"}, int'(dac), trial(e.vin, (cyc - e.acc) / (s + 1)));
    end else if (have && cyc == e.done) begin
      chk({nm, "_ready"}, int'(rdy), 1);
      chk({nm, "_data"}, int'(data), int'(e.vin));
      chk({nm, "_dac_final"}, int'(dac), int'(e.vin));
      chk({nm, "_busy_done"}, int'(bsy), 0);
    end else begin
      chk({nm, "_ready_idle"}, int'(rdy), 0);
      chk({nm, "_busy_idle"}, int'(bsy), 0);
      chk({nm, "_data_idle"}, int'(data), int'(last));
      chk({nm, "_dac_idle"}, int'(dac), int'(last));
    end
  endtask
  always @(negedge clk) if (started) begin
    if (q0.size() > 0) e0 = q0[0];
    if (q2.size() > 0) e2 = q2[0];
    mon("s0", S0, q0.size() > 0, e0, dac0, data0, rdy0, busy0, last0);
    mon("s2", S2, q2.size() > 0, e2, dac2, data2, rdy2, busy2, last2);
    if (held && rdy0) begin
      if (prev_r0 >= 0) chk("s0_ready_gap", cyc - prev_r0, L0 + 1);
      prev_r0 = cyc;
    end
    if (q0.size() > 0 && cyc >= q0[0].done) begin
      last0 = q0[0].vin;
      void'(q0.pop_front());
    end
    if (q2.size() > 0 && cyc >= q2[0].done) begin
      last2 = q2[0].vin;
      void'(q2.pop_front());
    end
  end
  task automatic tick(input bit s, input bit r, input logic [7:0] v0, input logic [7:0] v2);
    exp_t e;
    @(negedge clk);
    #1;
    reset = r;
    sample = s;
    if (q0.size() == 0) vin0 = v0;
    if (q2.size() == 0) vin2 = v2;
    if (r) begin
      q0.delete();
      q2.delete();
      last0 = 0;
      last2 = 0;
    end else if (s) begin
      if (q0.size() == 0) begin
        e = '{vin0, cyc + 1, cyc + 1 + L0};
        q0.push_back(e);
      end
      if (q2.size() == 0) begin
        e = '{vin2, cyc + 1, cyc + 1 + L2};
        q2.push_back(e);
      end
    end
  endtask
  task automatic idle_wait();
    for (int i = 0; i < 100 && (q0.size() + q2.size()) > 0; i++) tick(0, 0, vin0, vin2);
    chk("idle_timeout", q0.size() + q2.size(), 0);
    tick(0, 0, vin0, vin2);
  endtask
  task automatic conv(input logic [7:0] v);
    tick(1, 0, v, v);
    idle_wait();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    started = 1;
    reset = 0;
    tick(0, 0, 0, 0);
    conv(8'hA5);
    conv(8'h00);
    conv(8'hFF);
    conv(8'h3C);
    tick(1, 0, 8'h5A, 8'h5A);
    tick(0, 0, 8'h5A, 8'h5A);
    tick(0, 0, 8'h5A, 8'h5A);
    tick(1, 0, 8'h00, 8'h00);
    tick(0, 0, 8'h00, 8'h00);
    tick(1, 0, 8'h00, 8'h00);
    idle_wait();
    tick(1, 0, 8'h77, 8'h77);
    repeat (3) tick(0, 0, 8'h77, 8'h77);
    tick(0, 1, 8'h77, 8'h77);
    tick(0, 0, 8'h77, 8'h77);
    conv(8'h11);
    held = 1;
    prev_r0 = -1;
    tick(1, 0, 8'h20, 8'h20);
    for (int i = 0; i < 60; i++) tick(1, 0, 8'hE0, 8'hE0);
    held = 0;
    idle_wait();
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0, 8'($urandom), 8'($urandom));
    tick(0, 0, vin0, vin2);
    idle_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
